// File: rtl/ex_mem_pipe.sv
// EX->MEM elastic pipeline register with valid/ready handshake, flush and back-pressure.
// Define EX_MEM_SKID_BUF_EN to add a second (skid) entry and register the upstream ready.
module ex_mem_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [OP_W-1:0]       ex_memop,
  input  logic [DATA_W-1:0]     ex_maddr,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [OP_W-1:0]       mem_memop,
  output logic [DATA_W-1:0]     mem_maddr,
  output logic [1:0]            mem_count
);

  localparam int PW = REG_ADDR_W + 1 + DATA_W + OP_W + DATA_W;

  logic [PW-1:0] in_pl;
  logic          in_fire;
  logic          out_fire;

  logic          m_valid_q, m_valid_d;
  logic [PW-1:0] m_pl_q, m_pl_d;

  logic                  m_wreg_raw;
  logic [OP_W-1:0]       m_memop_raw;

  assign in_pl    = {ex_wd, ex_wreg, ex_wdata, ex_memop, ex_maddr};
  assign in_fire  = ex_valid & ex_ready;
  assign out_fire = m_valid_q & mem_ready;

`ifdef EX_MEM_SKID_BUF_EN
  logic          s_valid_q, s_valid_d;
  logic [PW-1:0] s_pl_q, s_pl_d;

  // Ready depends only on held state, breaking the mem_ready -> ex_ready path.
  assign ex_ready  = !rst & !s_valid_q;
  assign mem_count = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  always_comb begin
    m_valid_d = m_valid_q;
    m_pl_d    = m_pl_q;
    s_valid_d = s_valid_q;
    s_pl_d    = s_pl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || out_fire) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_pl_d    = s_pl_q;
        s_valid_d = in_fire;
        if (in_fire) s_pl_d = in_pl;
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_pl_d    = in_pl;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_pl_d    = in_pl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid_q <= 1'b0;
      s_pl_q    <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_pl_q    <= s_pl_d;
    end
  end
`else
  assign ex_ready  = !rst & (!m_valid_q | mem_ready);
  assign mem_count = {1'b0, m_valid_q};

  always_comb begin
    m_valid_d = m_valid_q;
    m_pl_d    = m_pl_q;
    if (flush) begin
      m_valid_d = 1'b0;
    end else if (in_fire) begin
      m_valid_d = 1'b1;
      m_pl_d    = in_pl;
    end else if (out_fire) begin
      m_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_pl_q    <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_pl_q    <= m_pl_d;
    end
  end

  assign {mem_wd, m_wreg_raw, mem_wdata, m_memop_raw, mem_maddr} = m_pl_q;

  // Side-effecting fields are masked in bubbles; plain data keeps its last value.
  assign mem_valid = m_valid_q;
  assign mem_wreg  = m_valid_q & m_wreg_raw;
  assign mem_memop = m_valid_q ? m_memop_raw : '0;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe; checks both with and without EX_MEM_SKID_BUF_EN.
module tb_ex_mem_pipe;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int OP_W   = 4;
  localparam int PW     = RA_W + 1 + DATA_W + OP_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst, flush, ex_valid, ex_ready;
  logic [RA_W-1:0]   ex_wd;
  logic              ex_wreg;
  logic [DATA_W-1:0] ex_wdata, ex_maddr;
  logic [OP_W-1:0]   ex_memop;
  logic              mem_valid, mem_ready;
  logic [RA_W-1:0]   mem_wd;
  logic              mem_wreg;
  logic [DATA_W-1:0] mem_wdata, mem_maddr;
  logic [OP_W-1:0]   mem_memop;
  logic [1:0]        mem_count;

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] sb_q[$];

  always #5 clk = ~clk;

  ex_mem_pipe #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_memop(ex_memop), .ex_maddr(ex_maddr),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_memop(mem_memop), .mem_maddr(mem_maddr), .mem_count(mem_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RA_W-1:0] wd, input logic wreg,
                       input logic [DATA_W-1:0] wdata, input logic [OP_W-1:0] memop,
                       input logic [DATA_W-1:0] maddr);
    ex_valid = v; ex_wd = wd; ex_wreg = wreg;
    ex_wdata = wdata; ex_memop = memop; ex_maddr = maddr;
  endtask

  // Monitor: compare every consumed output against the scoreboard, then log accepted inputs.
  always @(negedge clk) begin
    logic [PW-1:0] exp_pl;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (mem_valid && mem_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", {mem_wd, mem_wreg, mem_wdata, mem_memop, mem_maddr}, '0);
          if ({mem_wd, mem_wreg, mem_wdata, mem_memop, mem_maddr} == '0) begin
            errors++;
            $display("FAIL unexpected_output: got output entry expected none");
          end
        end else begin
          exp_pl = sb_q.pop_front();
          chk("out_payload", {mem_wd, mem_wreg, mem_wdata, mem_memop, mem_maddr}, exp_pl);
        end
      end
      if (!mem_valid) chk("bubble_mask", {mem_wreg, mem_memop}, '0);
      if (flush) sb_q.delete();
      else if (ex_valid && ex_ready)
        sb_q.push_back({ex_wd, ex_wreg, ex_wdata, ex_memop, ex_maddr});
    end
  end

  logic [DATA_W-1:0] svals[4];
  int k;

  initial begin
    svals[0] = 32'h11; svals[1] = 32'h22; svals[2] = 32'h33; svals[3] = 32'h44;
    rst = 1'b1; flush = 1'b0; mem_ready = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 32'hCAFE, 4'd1, 32'h40);

    // Reset
    @(posedge clk); @(negedge clk);
    chk("rst_ex_ready", ex_ready, 0);
    tick();
    @(negedge clk);
    chk("rst_ex_ready2", ex_ready, 0);
    chk("rst_outputs", {mem_valid, mem_wd, mem_wreg, mem_wdata, mem_memop, mem_maddr, mem_count}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("post_rst_ex_ready", ex_ready, 1);
    tick();

    // Streaming
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i + 1), 1'b1, svals[i], 4'(i + 1), 32'h100 + i);
      @(negedge clk);
      chk("stream_ex_ready", ex_ready, 1);
      if (i > 0) begin
        chk("stream_valid", mem_valid, 1);
        chk("stream_count", mem_count, 1);
        chk("stream_wdata", mem_wdata, svals[i-1]);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("stream_last", {mem_valid, mem_wdata}, {1'b1, 32'h44});
    tick();
    @(negedge clk);
    chk("stream_drained", {mem_valid, mem_count}, 3'b000);
    tick();

    // Back-pressure: mem_ready low in cycles 1..3
    k = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      mem_ready = !(cyc >= 1 && cyc <= 3);
      if (k < 6) drive(1'b1, 5'(k + 10), 1'b1, 32'hA1 + k, 4'(k + 2), 32'h200 + k);
      else       drive(1'b0, '0, 1'b0, '0, '0, '0);
      @(negedge clk);
`ifdef EX_MEM_SKID_BUF_EN
      if (cyc == 1) chk("bp_c1_ready", ex_ready, 1);
      if (cyc == 2 || cyc == 3) chk("bp_full", {ex_ready, mem_count}, {1'b0, 2'd2});
      if (cyc == 4) chk("bp_c4", {ex_ready, mem_wdata}, {1'b0, 32'hA1});
      if (cyc == 5) chk("bp_c5", {ex_ready, mem_count, mem_wdata}, {1'b1, 2'd1, 32'hA2});
`else
      if (cyc >= 1 && cyc <= 3)
        chk("bp_hold", {ex_ready, mem_count, mem_wdata}, {1'b0, 2'd1, 32'hA1});
      if (cyc == 4) chk("bp_release", ex_ready, 1);
`endif
      if (ex_valid && ex_ready) k++;
      tick();
    end
    chk("bp_all_sent", k, 6);
    @(negedge clk);
    chk("bp_drained", {mem_valid, mem_count}, 3'b000);
    tick();

    // Flush with entries held and a valid input offered
    mem_ready = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 32'hC1, 4'd3, 32'h300);
    tick();
`ifdef EX_MEM_SKID_BUF_EN
    drive(1'b1, 5'd4, 1'b1, 32'hC2, 4'd3, 32'h304);
    tick();
    @(negedge clk);
    chk("flush_pre_count", mem_count, 2);
`else
    @(negedge clk);
    chk("flush_pre_count", mem_count, 1);
`endif
    @(posedge clk); #1;
    flush = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 32'hDEAD, 4'd3, 32'h308);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("flush_after", {mem_valid, mem_wreg, mem_memop, mem_count}, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("flush_no_ghost", mem_valid, 0);
    end
    tick();

    // Bubble after single consumed entry
    drive(1'b1, 5'd7, 1'b1, 32'hB0B0, 4'd2, 32'h400);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("bubble_entry", {mem_valid, mem_wreg, mem_memop}, {1'b1, 1'b1, 4'd2});
    tick();
    @(negedge clk);
    chk("bubble_out", {mem_valid, mem_wreg, mem_memop}, '0);
    chk("bubble_hold", {mem_wd, mem_wdata, mem_maddr}, {5'd7, 32'hB0B0, 32'h400});
    tick();

    // Reset mid-transfer
    mem_ready = 1'b0;
    drive(1'b1, 5'd8, 1'b1, 32'hE1, 4'd5, 32'h500);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst", {mem_valid, mem_count, mem_wdata, ex_ready}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    tick(); tick();
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
